// File: rtl/audio_pkg.sv
// Shared audio constants and sample type for the note-generation and I2S transmit stages.
// The SOFT_MUTE_EN build uses attenuate() for the mute ramp.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 10;
  localparam int SLOT_W   = 5;
  localparam int SLOT_MSB = 1;
  localparam int SLOT_LSB = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // Arithmetic right shift by the attenuation step; full attenuation is hard silence.
  function automatic logic [SAMPLE_W-1:0] attenuate(input logic [SAMPLE_W-1:0] s,
                                                    input logic [3:0] a);
    logic signed [SAMPLE_W-1:0] ss;
    ss = s;
    if (a == 4'd15) return '0;
    return ss >>> a;
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter for the I2S transmitter: MCLK/SCK/LRCK taps, frame boundary and
// sdin update strobes, and the position (LRCK half + slot) that the next SCK period will carry.
module i2s_clkgen
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                mclk,
  output logic                sck,
  output logic                lrck,
  output logic                boundary,
  output logic                sdin_update,
  output logic                frame_start,
  output logic [SLOT_W:0]     next_pos
);
  logic [CNT_W-1:0] cnt;
  logic             frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt           <= cnt + 1'b1;
      frame_start_q <= boundary;
    end
  end

  assign mclk        = cnt[1];
  assign sck         = cnt[3];
  assign lrck        = cnt[CNT_W-1];
  assign boundary    = &cnt;
  assign sdin_update = &cnt[3:0];
  // Registered so the pulse is high while cnt==0 yet stays low throughout reset.
  assign frame_start = frame_start_q;
  // {lrck, slot} of the SCK period that starts after the current one; wraps 63 -> 0 at the boundary.
  assign next_pos    = cnt[CNT_W-1:4] + 1'b1;
endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo PCM to I2S serialiser for the CS4344: pending buffer, per-frame shadow and bit mux.
// Build option SOFT_MUTE_EN: mute ramps via a 4-bit attenuation register instead of hard zero.
module i2s_tx_stream
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                mute,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin,
  output logic                frame_start,
  output logic                underrun
);
  // Handshake: a sample transfers on any clk edge where in_valid & in_ready; in_ready is
  // !pend_full straight from the register, and in_valid/data must hold until that edge.
  logic           boundary, sdin_update;
  logic [SLOT_W:0] next_pos;
  logic           pend_full, accept, sdin_q, bit_nxt;
  stereo_sample_t pend_q, last_q, shadow_q, src, loaded;
  logic [SAMPLE_W-1:0] word;
  logic [SLOT_W-1:0]   slot;
  logic [3:0]          bit_idx;

  i2s_clkgen u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .mclk        (audio_mclk),
    .sck         (audio_sck),
    .lrck        (audio_lrck),
    .boundary    (boundary),
    .sdin_update (sdin_update),
    .frame_start (frame_start),
    .next_pos    (next_pos)
  );

  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;
  assign underrun = boundary && !pend_full;
  // On underrun the last unscaled sample is replayed so mute still applies to it.
  assign src      = pend_full ? pend_q : last_q;

`ifdef SOFT_MUTE_EN
  logic [3:0] atten_q, atten_nxt;

  always_comb begin
    atten_nxt = atten_q;
    if (mute && atten_q != 4'd15)       atten_nxt = atten_q + 4'd1;
    else if (!mute && atten_q != 4'd0)  atten_nxt = atten_q - 4'd1;
    loaded.left  = attenuate(src.left,  atten_nxt);
    loaded.right = attenuate(src.right, atten_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           atten_q <= 4'd0;
    else if (boundary) atten_q <= atten_nxt;
  end
`else
  assign loaded = mute ? '0 : src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_q    <= '0;
      last_q    <= '0;
      shadow_q  <= '0;
    end else begin
      if (boundary) begin
        shadow_q <= loaded;
        last_q   <= src;
      end
      if (boundary && pend_full) pend_full <= 1'b0;
      else if (accept)           pend_full <= 1'b1;
      if (accept) pend_q <= {in_left, in_right};
    end
  end

  // Slot 0 is the I2S one-bit delay; slots 1..16 carry MSB..LSB; the rest pad with zeros.
  always_comb begin
    slot    = next_pos[SLOT_W-1:0];
    word    = next_pos[SLOT_W] ? shadow_q.right : shadow_q.left;
    bit_idx = 4'(SAMPLE_W - int'(slot));
    bit_nxt = 1'b0;
    if (int'(slot) >= SLOT_MSB && int'(slot) <= SLOT_LSB) bit_nxt = word[bit_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sdin_q <= 1'b0;
    else if (sdin_update) sdin_q <= bit_nxt;
  end

  assign audio_sdin = sdin_q;
endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream: clock/reset, driver tasks, per-frame scoreboard, final report.
// Expectations follow the SOFT_MUTE_EN build when that macro is defined.
module tb_i2s_tx_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        mute = 1'b0;
  logic        audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start, underrun;

  i2s_tx_stream dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .mute        (mute),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .audio_sdin  (audio_sdin),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Reference frame position, independent of the DUT.
  logic [9:0] tb_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 10'd1;
  end

`ifdef SOFT_MUTE_EN
  localparam int MUTE_N = 16;
  localparam int N_ITER = 34;
`else
  localparam int MUTE_N = 2;
  localparam int N_ITER = 5;
`endif

  logic [15:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int n_mclk, n_sck, n_lrck, n_fs, n_ur, pad_ones;
  logic p_mclk = 1'b0, p_sck = 1'b0, p_lrck = 1'b0;
  logic [15:0] cap_l, cap_r;
  logic mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back(l);
    exp_q.push_back(r);
  endtask

  task automatic frame_compare();
    logic [15:0] el, er;
    if (exp_q.size() < 2) begin
      check("exp_q_depth", exp_q.size(), 2);
    end else begin
      el = exp_q.pop_front();
      er = exp_q.pop_front();
      check("frame_left", {16'd0, cap_l}, {16'd0, el});
      check("frame_right", {16'd0, cap_r}, {16'd0, er});
      check("pad_bits", pad_ones, 0);
    end
  endtask

  // One clk cycle: sample everything at the falling edge, capture sdin at SCK rises.
  task automatic step();
    int slot;
    @(negedge clk);
    if (rst) begin
      cap_l = '0; cap_r = '0; pad_ones = 0;
    end else begin
      if (audio_mclk && !p_mclk) n_mclk++;
      if (audio_sck && !p_sck)   n_sck++;
      if (audio_lrck && !p_lrck) n_lrck++;
      if (frame_start) n_fs++;
      if (underrun)    n_ur++;
      if (tb_cnt[3:0] == 4'd8) begin
        slot = int'(tb_cnt[8:4]);
        if (slot >= 1 && slot <= 16) begin
          if (tb_cnt[9]) cap_r[4'(16 - slot)] = audio_sdin;
          else           cap_l[4'(16 - slot)] = audio_sdin;
        end else if (audio_sdin) pad_ones++;
      end
      if (tb_cnt == 10'd1023) begin
        if (mon_en) frame_compare();
        cap_l = '0; cap_r = '0; pad_ones = 0;
      end
    end
    p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
  endtask

  task automatic wait_cnt(input logic [9:0] target);
    int k = 0;
    do begin
      step();
      k++;
    end while (tb_cnt != target && k < 2100);
    if (tb_cnt != target) check("wait_timeout", {22'd0, tb_cnt}, {22'd0, target});
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int k = 0;
    while (!in_ready && k < 2100) begin
      step();
      k++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1);
    in_valid = 1'b1; in_left = l; in_right = r;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] scale(input logic [15:0] x, input int a);
    logic signed [15:0] s;
    s = x;
    if (a >= 15) return 16'd0;
    return s >>> a;
  endfunction

  initial begin
    int atten_m;
    logic m;
    // Reset behaviour and free-running clocks with no data.
    repeat (5) step();
    check("rst_outputs", {audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start, underrun}, 0);
    check("rst_in_ready", in_ready, 1);
    push_exp(16'h0000, 16'h0000);
    push_exp(16'h0000, 16'h0000);
    rst = 1'b0;
    n_mclk = 0; n_sck = 0; n_lrck = 0; n_fs = 0; n_ur = 0;
    repeat (2048) step();
    check("mclk_rises", n_mclk, 512);
    check("sck_rises", n_sck, 128);
    check("lrck_rises", n_lrck, 2);
    check("frame_start_cnt", n_fs, 2);
    check("underrun_idle", n_ur, 2);

    // First sample: held pending until the boundary, plays in the following frame.
    push_exp(16'h0000, 16'h0000);
    push_exp(16'hA5C3, 16'h0F0F);
    push(16'hA5C3, 16'h0F0F);
    check("ready_after_push", in_ready, 0);
    wait_cnt(10'd1023);
    check("ready_at_boundary", in_ready, 0);
    check("no_underrun_full", underrun, 0);
    step();
    check("ready_after_boundary", in_ready, 1);
    check("frame_start_pulse", frame_start, 1);

    // Starved frame: one underrun, sample repeats.
    push_exp(16'hA5C3, 16'h0F0F);
    n_ur = 0;
    wait_cnt(10'd1023);
    check("underrun_once", n_ur, 1);

    // Push on the boundary cycle with pending empty.
    push_exp(16'hA5C3, 16'h0F0F);
    push_exp(16'h1234, 16'h8001);
    wait_cnt(10'd1023);
    in_valid = 1'b1; in_left = 16'h1234; in_right = 16'h8001;
    check("underrun_with_push", underrun, 1);
    check("ready_on_boundary", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("accepted_on_boundary", in_ready, 0);
    n_ur = 0;
    wait_cnt(10'd1023);
    check("no_underrun_next", n_ur, 0);

    // Mute on and off with a fresh sample every frame.
    atten_m = 0;
    for (int k = 0; k < N_ITER; k++) begin
      push(16'h4000, 16'hC000);
      m = (k >= 1 && k <= MUTE_N);
      mute = m;
`ifdef SOFT_MUTE_EN
      if (m && atten_m < 15) atten_m++;
      else if (!m && atten_m > 0) atten_m--;
      push_exp(scale(16'h4000, atten_m), scale(16'hC000, atten_m));
`else
      if (m) push_exp(16'h0000, 16'h0000);
      else   push_exp(16'h4000, 16'hC000);
`endif
      wait_cnt(10'd1023);
    end
    mute = 1'b0;
    wait_cnt(10'd1023);

    // Reset mid-frame with a sample pending.
    push(16'hFFFF, 16'hFFFF);
    mon_en = 1'b0;
    wait_cnt(10'd300);
    rst = 1'b1;
    #1;
    check("midrst_clocks", {audio_mclk, audio_sck, audio_lrck}, 0);
    check("midrst_sdin", audio_sdin, 0);
    check("midrst_ready", in_ready, 1);
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;
    check("ready_after_rst", in_ready, 1);
    push_exp(16'h0000, 16'h0000);
    push_exp(16'h0000, 16'h0000);
    n_ur = 0;
    wait_cnt(10'd1023);
    wait_cnt(10'd1023);
    check("pending_dropped", n_ur, 2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
